div_32bit: RTL and testbench

DIV_32BIT -- requirements
Module: div_32bit

---
 rtl/div_32bit.sv | 169 ++++++++++++++++
 tb/tb_div_32bit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_32bit.sv
// ============================================================================
//  Module   : div_32bit
//  Purpose  : Signed 32-bit restoring divider, one quotient bit per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_32bit (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrlDiv,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        exception,
   output logic        resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [31:0] C_MIN_INT  = 32'h8000_0000;
   localparam logic [31:0] C_NEG_ONE  = 32'hFFFF_FFFF;
   localparam logic [5:0]  C_LAST_IT  = 6'd31;

   state_t      r_state;
   state_t      w_nextState;

   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_divMag;
   logic [5:0]  r_count;
   logic        r_quoNeg;
   logic        r_remNeg;
   logic        r_exc;

   logic        w_divZero;
   logic        w_overflow;
   logic [32:0] w_dividendExt;
   logic [32:0] w_divisorExt;
   logic [32:0] w_dividendAbs;
   logic [32:0] w_divisorAbs;
   logic [63:0] w_shifted;
   logic [32:0] w_trial;

   assign w_divZero  = (divisor == 32'd0);
   assign w_overflow = (dividend == C_MIN_INT) && (divisor == C_NEG_ONE);

   // Sign-extend to 33 bits so |-2^31| comes out as an exact 2^31
   assign w_dividendExt = {dividend[31], dividend};
   assign w_divisorExt  = {divisor[31], divisor};
   assign w_dividendAbs = dividend[31] ? (33'd0 - w_dividendExt) : w_dividendExt;
   assign w_divisorAbs  = divisor[31]  ? (33'd0 - w_divisorExt)  : w_divisorExt;

   // Remainder never exceeds 2^31-1 here, so the shifted value fits in 32 bits
   assign w_shifted = {r_rem, r_quo} << 1;
   assign w_trial   = {1'b0, w_shifted[63:32]} - {1'b0, r_divMag};

   assign busy = (r_state != IDLE);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (ctrlDiv) begin
               if (w_divZero || w_overflow) begin
                  w_nextState = DONE;
               end else begin
                  w_nextState = RUN;
               end
            end
         end
         RUN: begin
            if (r_count == C_LAST_IT) begin
               w_nextState = FIX;
            end
         end
         FIX:     w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rem     <= 32'd0;
         r_quo     <= 32'd0;
         r_divMag  <= 32'd0;
         r_count   <= 6'd0;
         r_quoNeg  <= 1'b0;
         r_remNeg  <= 1'b0;
         r_exc     <= 1'b0;
         quotient  <= 32'd0;
         remainder <= 32'd0;
         exception <= 1'b0;
         resultRDY <= 1'b0;
      end else begin
         resultRDY <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ctrlDiv) begin
                  r_count  <= 6'd0;
                  r_quoNeg <= dividend[31] ^ divisor[31];
                  r_remNeg <= dividend[31];
                  r_divMag <= w_divisorAbs[31:0];
                  // Exceptional cases preload their final result and skip RUN/FIX
                  if (w_divZero) begin
                     r_quo <= 32'd0;
                     r_rem <= dividend;
                     r_exc <= 1'b1;
                  end else if (w_overflow) begin
                     r_quo <= C_MIN_INT;
                     r_rem <= 32'd0;
                     r_exc <= 1'b1;
                  end else begin
                     r_quo <= w_dividendAbs[31:0];
                     r_rem <= 32'd0;
                     r_exc <= 1'b0;
                  end
               end
            end
            RUN: begin
               r_count <= r_count + 6'd1;
               if (!w_trial[32]) begin
                  r_rem <= w_trial[31:0];
                  r_quo <= {w_shifted[31:1], 1'b1};
               end else begin
                  r_rem <= w_shifted[63:32];
                  r_quo <= w_shifted[31:0];
               end
            end
            FIX: begin
               if (r_quoNeg) begin
                  r_quo <= 32'd0 - r_quo;
               end
               if (r_remNeg) begin
                  r_rem <= 32'd0 - r_rem;
               end
            end
            DONE: begin
               quotient  <= r_quo;
               remainder <= r_rem;
               exception <= r_exc;
               resultRDY <= 1'b1;
            end
            default: begin
               resultRDY <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_32bit.sv
// ============================================================================
//  Module   : tb_div_32bit
//  Purpose  : Directed and random checks of div_32bit against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_32bit;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrlDiv;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        exception;
   logic        resultRDY;
   logic        busy;

   int nVec = 0;
   int nErr = 0;

   div_32bit dut (
      .clock     (clock),
      .reset     (reset),
      .ctrlDiv   (ctrlDiv),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .exception (exception),
      .resultRDY (resultRDY),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed arithmetic, '/' truncates toward zero, '%' follows dividend sign
   function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         q = 32'd0; r = a; e = 1'b1;
      end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
         q = 32'h8000_0000; r = 32'd0; e = 1'b1;
      end else begin
         q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
      end
   endfunction

   // Runs one division; pokeAt>0 issues a spurious start after that many edges
   task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input int pokeAt);
      logic [31:0] eq;
      logic [31:0] er;
      logic        ee;
      int          expLat;
      int          edges;
      bit          seen;
      refDiv(a, b, eq, er, ee);
      expLat = ee ? 1 : 34;
      @(negedge clock);
      dividend = a; divisor = b; ctrlDiv = 1'b1;
      @(posedge clock); #1;
      ctrlDiv  = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      chk("busyAfterStart", {31'd0, busy}, 32'd1);
      edges = 0; seen = 1'b0;
      while (!seen && edges < 100) begin
         @(posedge clock); #1;
         edges++;
         if (resultRDY) begin
            seen = 1'b1;
         end else if (edges == pokeAt) begin
            ctrlDiv = 1'b1; dividend = 32'd999; divisor = 32'd3;
         end else begin
            ctrlDiv = 1'b0;
         end
      end
      ctrlDiv = 1'b0;
      chk("latency", seen ? 32'(edges) : 32'hFFFF_FFFF, 32'(expLat));
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("exception", {31'd0, exception}, {31'd0, ee});
      chk("busyAtResult", {31'd0, busy}, 32'd0);
      @(posedge clock); #1;
      chk("rdyOnePulse", {31'd0, resultRDY}, 32'd0);
      chk("quotientHold", quotient, eq);
   endtask

   initial begin
      int pulses;
      logic [31:0] ra;
      logic [31:0] rb;

      reset = 1'b0; ctrlDiv = 1'b0; dividend = 32'd0; divisor = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      chk("rstQuotient", quotient, 32'd0);
      chk("rstRemainder", remainder, 32'd0);
      chk("rstException", {31'd0, exception}, 32'd0);
      chk("rstRdy", {31'd0, resultRDY}, 32'd0);
      chk("rstBusy", {31'd0, busy}, 32'd0);
      reset = 1'b1;

      runDiv(32'd100, 32'd7, 0);
      runDiv(-32'sd100, 32'd7, 0);
      runDiv(32'd100, -32'sd7, 0);
      runDiv(32'd12345, 32'd0, 0);
      runDiv(32'h8000_0000, 32'hFFFF_FFFF, 0);
      runDiv(32'h8000_0000, 32'd1, 0);
      runDiv(32'd1000, 32'd7, 10);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = 32'd0 - 32'($urandom_range(1, 20));
            default: rb = {16'd0, 16'($urandom)};
         endcase
         runDiv(ra, rb, 0);
      end

      // Abort mid-run: the result registers must clear and no pulse may follow
      runDiv(32'd50, 32'd3, 0);
      @(negedge clock);
      dividend = 32'h0012_3456; divisor = 32'd5; ctrlDiv = 1'b1;
      @(posedge clock); #1;
      ctrlDiv = 1'b0;
      pulses = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clock); #1;
         if (resultRDY) pulses++;
      end
      reset = 1'b0;
      @(posedge clock); #1;
      chk("abortQuotient", quotient, 32'd0);
      chk("abortRemainder", remainder, 32'd0);
      chk("abortException", {31'd0, exception}, 32'd0);
      chk("abortRdy", {31'd0, resultRDY}, 32'd0);
      chk("abortBusy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      for (int e = 0; e < 40; e++) begin
         @(posedge clock); #1;
         if (resultRDY) pulses++;
      end
      chk("abortNoPulse", 32'(pulses), 32'd0);
      runDiv(32'd7, 32'd7, 0);

      // Reset wins over a simultaneous start
      @(negedge clock);
      reset = 1'b0; ctrlDiv = 1'b1; dividend = 32'd9; divisor = 32'd2;
      @(posedge clock); #1;
      chk("rstPriorityBusy", {31'd0, busy}, 32'd0);
      reset = 1'b1; ctrlDiv = 1'b0;
      runDiv(-32'sd9, -32'sd2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

`default_nettype wire
